frame_buffer_writer: RTL and testbench

Write-side front end of the panel frame buffer. Accepts a raster pixel stream (RGB444, 48 columns x 64 rows) over a valid/ready handshake and writes each pixel into the correct half-panel bank RAM (b1 = rows 0-31, b2 = rows 32-63) at the address the panel scan side reads. Double-buffers the RAMs with two pages. Swaps pages only on a frame-done pulse from the scan side, so a partial frame is never displayed.

---
 rtl/frame_buffer_writer_if.sv | 29 ++
 rtl/frame_buffer_writer.sv | 189 ++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream, RAM write-port and page-swap signals of the frame buffer writer.
interface frame_buffer_writer_if #(
    parameter int ADDR_W = 12
);
    logic [11:0]       i_pix_data;
    logic              i_pix_valid;
    logic              i_pix_sof;
    logic              o_pix_ready;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [11:0]       o_wr_data;
    logic              o_wr_en_b1;
    logic              o_wr_en_b2;
    logic              i_frame_done;
    logic              o_page;
    logic              o_busy;
    logic              o_sof_err;

    modport master (
        output i_pix_data, i_pix_valid, i_pix_sof, i_frame_done,
        input  o_pix_ready, o_wr_addr, o_wr_data, o_wr_en_b1, o_wr_en_b2,
               o_page, o_busy, o_sof_err
    );

    modport slave (
        input  i_pix_data, i_pix_valid, i_pix_sof, i_frame_done,
        output o_pix_ready, o_wr_addr, o_wr_data, o_wr_en_b1, o_wr_en_b2,
               o_page, o_busy, o_sof_err
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// Raster pixel stream to double-buffered half-panel bank RAM writer.
// Optional FRAME_BUF_GAMMA_EN adds a gamma LUT and one extra write pipeline stage.
module frame_buffer_writer #(
    parameter int COLS          = 48,
    parameter int ROWS_PER_BANK = 32,
    parameter int ADDR_W        = 12
) (
    input logic                  i_clk,
    input logic                  i_rst,
    frame_buffer_writer_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS_PER_BANK) + 1;
    localparam logic [ADDR_W-1:0] PAGE_SIZE = ADDR_W'(COLS * ROWS_PER_BANK);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(2 * ROWS_PER_BANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_e;

    state_e            state_q;
    logic              page_q;
    logic              pix_ready_q;
    logic              busy_q;
    logic              sof_err_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;
    logic              wr_en_b1_q;
    logic              wr_en_b2_q;

    logic              accept_s;
    logic              swap_block_s;
    logic [ADDR_W-1:0] page_off_d;
    logic [ADDR_W-1:0] beat_addr_d;
    logic              row_wrap_d;
    logic              last_beat_d;

    // Beat acceptance and write address of the current beat (writes go to the hidden page)
    always_comb begin
        accept_s    = bus.i_pix_valid && pix_ready_q;
        page_off_d  = page_q ? {ADDR_W{1'b0}} : PAGE_SIZE;
        beat_addr_d = page_off_d + row_base_q + ADDR_W'(col_q);
        row_wrap_d  = (row_q[ROW_W-2:0] == {(ROW_W-1){1'b1}});
        last_beat_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Frame FSM, raster counters and first write stage
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            page_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            sof_err_q   <= 1'b0;
            col_q       <= {COL_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            row_base_q  <= {ADDR_W{1'b0}};
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= 12'd0;
            wr_en_b1_q  <= 1'b0;
            wr_en_b2_q  <= 1'b0;
        end else begin
            wr_en_b1_q <= 1'b0;
            wr_en_b2_q <= 1'b0;
            sof_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WRITE: begin
                    pix_ready_q <= 1'b1;
                    if (accept_s && bus.i_pix_sof) begin
                        // SOF always restarts the frame at pixel (0,0), flagged if mid-frame
                        sof_err_q  <= (state_q == ST_WRITE);
                        wr_addr_q  <= page_off_d;
                        wr_data_q  <= bus.i_pix_data;
                        wr_en_b1_q <= 1'b1;
                        col_q      <= COL_W'(1);
                        row_q      <= {ROW_W{1'b0}};
                        row_base_q <= {ADDR_W{1'b0}};
                        state_q    <= ST_WRITE;
                        busy_q     <= 1'b1;
                    end else if (accept_s && (state_q == ST_WRITE)) begin
                        wr_addr_q  <= beat_addr_d;
                        wr_data_q  <= bus.i_pix_data;
                        wr_en_b1_q <= ~row_q[ROW_W-1];
                        wr_en_b2_q <= row_q[ROW_W-1];
                        if (col_q == COL_LAST) begin
                            col_q      <= {COL_W{1'b0}};
                            row_q      <= row_q + ROW_W'(1);
                            row_base_q <= row_wrap_d ? {ADDR_W{1'b0}} : (row_base_q + ROW_STEP);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                        if (last_beat_d) begin
                            state_q     <= ST_WAIT_SWAP;
                            pix_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (bus.i_frame_done && !swap_block_s) begin
                        page_q      <= ~page_q;
                        state_q     <= ST_IDLE;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        pix_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_BUF_GAMMA_EN
    logic [ADDR_W-1:0] out_addr_q;
    logic [11:0]       out_data_q;
    logic              out_en_b1_q;
    logic              out_en_b2_q;

    function automatic logic [3:0] gamma4(input logic [3:0] v);
        case (v)
            4'd0:    gamma4 = 4'd0;
            4'd1:    gamma4 = 4'd0;
            4'd2:    gamma4 = 4'd0;
            4'd3:    gamma4 = 4'd0;
            4'd4:    gamma4 = 4'd0;
            4'd5:    gamma4 = 4'd1;
            4'd6:    gamma4 = 4'd1;
            4'd7:    gamma4 = 4'd2;
            4'd8:    gamma4 = 4'd3;
            4'd9:    gamma4 = 4'd4;
            4'd10:   gamma4 = 4'd6;
            4'd11:   gamma4 = 4'd7;
            4'd12:   gamma4 = 4'd9;
            4'd13:   gamma4 = 4'd10;
            4'd14:   gamma4 = 4'd12;
            4'd15:   gamma4 = 4'd15;
            default: gamma4 = 4'd0;
        endcase
    endfunction

    // Gamma-corrected second write stage
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            out_addr_q  <= {ADDR_W{1'b0}};
            out_data_q  <= 12'd0;
            out_en_b1_q <= 1'b0;
            out_en_b2_q <= 1'b0;
        end else begin
            out_addr_q  <= wr_addr_q;
            out_data_q  <= {gamma4(wr_data_q[11:8]), gamma4(wr_data_q[7:4]), gamma4(wr_data_q[3:0])};
            out_en_b1_q <= wr_en_b1_q;
            out_en_b2_q <= wr_en_b2_q;
        end
    end

    // A write still in the first stage must land before the page may swap
    assign swap_block_s   = wr_en_b1_q | wr_en_b2_q;
    assign bus.o_wr_addr  = out_addr_q;
    assign bus.o_wr_data  = out_data_q;
    assign bus.o_wr_en_b1 = out_en_b1_q;
    assign bus.o_wr_en_b2 = out_en_b2_q;
`else
    assign swap_block_s   = 1'b0;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_wr_en_b1 = wr_en_b1_q;
    assign bus.o_wr_en_b2 = wr_en_b2_q;
`endif

    assign bus.o_pix_ready = pix_ready_q;
    assign bus.o_page      = page_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_sof_err   = sof_err_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized directed bench for frame_buffer_writer against a pixel-index reference model.
module tb_frame_buffer_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_buffer_writer_if #(.ADDR_W(12)) bus();

    frame_buffer_writer #(.COLS(48), .ROWS_PER_BANK(32), .ADDR_W(12)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec;
    int n_err;

    // Reference model: frame progress tracked as a linear pixel index
    bit          m_known;
    bit          m_rdy;
    bit          m_inframe;
    bit          m_wait;
    bit          m_page;
    bit          m_busy;
    bit          m_err;
    bit          m_en1;
    bit          m_en2;
    int          m_idx;
    logic [11:0] m_addr;
    logic [11:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [11:0] d, input bit fd);
        bit acc;
        int row;
        int col;
        @(negedge clk);
        if (m_known) chk("ready_pre_edge", 32'(bus.o_pix_ready), 32'(m_rdy));
        rst              = r;
        bus.i_pix_valid  = v;
        bus.i_pix_sof    = s;
        bus.i_pix_data   = d;
        bus.i_frame_done = fd;
        @(posedge clk);
        m_en1 = 1'b0;
        m_en2 = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_known   = 1'b1;
            m_rdy     = 1'b0;
            m_inframe = 1'b0;
            m_wait    = 1'b0;
            m_page    = 1'b0;
            m_idx     = 0;
            m_addr    = 12'd0;
            m_data    = 12'd0;
        end else begin
            acc = v && m_rdy;
            if (m_wait) begin
                if (fd) begin
                    m_page = !m_page;
                    m_wait = 1'b0;
                end
            end else if (acc && (s || m_inframe)) begin
                if (s) begin
                    m_err     = m_inframe;
                    m_idx     = 0;
                    m_inframe = 1'b1;
                end
                row    = m_idx / 48;
                col    = m_idx % 48;
                m_addr = 12'((m_page ? 0 : 1536) + (row % 32) * 48 + col);
                m_data = d;
                m_en1  = (row < 32);
                m_en2  = (row >= 32);
                m_idx++;
                if (m_idx == 3072) begin
                    m_inframe = 1'b0;
                    m_wait    = 1'b1;
                end
            end
            m_rdy = !m_wait;
        end
        m_busy = m_inframe || m_wait;
        #1;
        chk("wr_en_b1", 32'(bus.o_wr_en_b1), 32'(m_en1));
        chk("wr_en_b2", 32'(bus.o_wr_en_b2), 32'(m_en2));
        chk("wr_addr", 32'(bus.o_wr_addr), 32'(m_addr));
        chk("wr_data", 32'(bus.o_wr_data), 32'(m_data));
        chk("pix_ready", 32'(bus.o_pix_ready), 32'(m_rdy));
        chk("page", 32'(bus.o_page), 32'(m_page));
        chk("busy", 32'(bus.o_busy), 32'(m_busy));
        chk("sof_err", 32'(bus.o_sof_err), 32'(m_err));
    endtask

    // n beats with sof on beat 0 and on beat sof_at; frame_done raised with beat fd_at
    task automatic send_frame(input int n, input int gap_max, input bit rand_data,
                              input int sof_at, input int fd_at);
        for (int i = 0; i < n; i++) begin
            int          g;
            logic [11:0] d;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                step(1'b1, 1'b0, 1'($urandom), 12'($urandom), ($urandom_range(63, 0) == 0));
            end
            d = rand_data ? 12'($urandom) : 12'(i);
            step(1'b1, 1'b1, (i == 0) || (i == sof_at), d, (i == fd_at));
        end
    endtask

    // Offered beats must be refused while waiting; then one frame_done swaps the page
    task automatic finish_frame(input int hold);
        for (int k = 0; k < hold; k++) begin
            step(1'b1, 1'($urandom), 1'b0, 12'($urandom), 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 12'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        m_known          = 1'b0;
        rst              = 1'b0;
        bus.i_pix_valid  = 1'b0;
        bus.i_pix_sof    = 1'b0;
        bus.i_pix_data   = 12'd0;
        bus.i_frame_done = 1'b0;

        step(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 12'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);

        // Frame 1: back-to-back beats, data = index, lands on page 1
        send_frame(3072, 0, 1'b0, -1, -1);
        finish_frame(4);

        // Frame 2: random data with gaps, lands on page 0
        send_frame(3072, 2, 1'b1, -1, -1);
        finish_frame(3);

        // Non-SOF beats in IDLE are dropped, then a mid-frame SOF at beat 100
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 12'($urandom), 1'b0);
        end
        send_frame(3172, 1, 1'b1, 100, -1);
        finish_frame(2);

        // Reset in the middle of a frame, then a full frame whose last beat meets frame_done
        send_frame(700, 1, 1'b1, -1, -1);
        step(1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        send_frame(3072, 1, 1'b0, -1, 3071);
        finish_frame(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
